// File: rtl/life_pkg.sv
// Shared Game-of-Life definitions: controller state encoding and the cell-index
// mapping used by the controller, evolution and display stages.
package life_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EVOLVE = 2'd1,
      ST_COMMIT = 2'd2
   } life_state_e;

   // Linear board index of cell (x,y) on a board n cells wide.
   function automatic int unsigned idx(input int unsigned x, input int unsigned y,
                                       input int unsigned n);
      return y * n + x;
   endfunction

endpackage

// File: rtl/life_board_ctrl_if.sv
// Command, evolution-stage and display bundle of the board controller.
interface life_board_ctrl_if #(
   parameter int P_PARAM_N = 5,
   parameter int P_PARAM_M = 5,
   parameter int P_GEN_W   = 16
) ();
   localparam int XW    = (P_PARAM_N > 1) ? $clog2(P_PARAM_N) : 1;
   localparam int YW    = (P_PARAM_M > 1) ? $clog2(P_PARAM_M) : 1;
   localparam int CELLS = P_PARAM_N * P_PARAM_M;

   logic               run;
   logic               step;
   logic               clear;
   logic               edit_valid;
   logic [XW-1:0]      edit_x;
   logic [YW-1:0]      edit_y;
   logic               edit_val;
   logic [CELLS-1:0]   board_prev;
   logic [CELLS-1:0]   evo_next;
   logic [CELLS-1:0]   board;
   logic [P_GEN_W-1:0] generation;
   logic               busy;
   logic               edit_ack;

   modport slave (
      input  run, step, clear, edit_valid, edit_x, edit_y, edit_val, evo_next,
      output board_prev, board, generation, busy, edit_ack
   );

   modport master (
      output run, step, clear, edit_valid, edit_x, edit_y, edit_val, evo_next,
      input  board_prev, board, generation, busy, edit_ack
   );
endinterface

// File: rtl/life_tick_gen.sv
// Auto-run generation divider: one-cycle tick every P_TICK_DIV enabled cycles.
module life_tick_gen #(
   parameter int P_TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);
   localparam int             CW       = (P_TICK_DIV > 1) ? $clog2(P_TICK_DIV) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(P_TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = en_i && (cnt_q == CNT_LAST);

   // Next count: clear dominates, otherwise count and wrap while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/life_board_ctrl.sv
// Game-of-Life board owner: applies clear/edit commands and sequences
// IDLE -> EVOLVE -> COMMIT generations through the external evolution stage.
module life_board_ctrl
   import life_pkg::*;
#(
   parameter int P_PARAM_N  = 5,
   parameter int P_PARAM_M  = 5,
   parameter int P_TICK_DIV = 50_000_000,
   parameter int P_EVO_LAT  = 2,
   parameter int P_GEN_W    = 16
) (
   input logic              clk,
   input logic              rst_n,
   life_board_ctrl_if.slave bus
);
   localparam int CELLS = P_PARAM_N * P_PARAM_M;
   localparam int XW    = (P_PARAM_N > 1) ? $clog2(P_PARAM_N) : 1;
   localparam int YW    = (P_PARAM_M > 1) ? $clog2(P_PARAM_M) : 1;
   localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam int LAT_W = (P_EVO_LAT > 1) ? $clog2(P_EVO_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(P_EVO_LAT - 1);

   life_state_e        state_q, state_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   logic [CELLS-1:0]   board_q, board_d;
   logic [P_GEN_W-1:0] gen_q, gen_d;
   logic               busy_q, busy_d;
   logic               ack_q, ack_d;
   logic               pend_q, pend_d;
   logic               tick_s, trig_s, clear_exec_s, edit_hit_s;
   logic [IW-1:0]      cell_sel_s;

   life_tick_gen #(.P_TICK_DIV(P_TICK_DIV)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (bus.run),
      .clr_i  (!bus.run || clear_exec_s),
      .tick_o (tick_s)
   );

   // Step pulses only count while paused; ticks only while running.
   assign trig_s     = bus.run ? tick_s : bus.step;
   assign edit_hit_s = ({1'b0, bus.edit_x} < (XW+1)'(P_PARAM_N)) &&
                       ({1'b0, bus.edit_y} < (YW+1)'(P_PARAM_M));
   assign cell_sel_s = IW'(idx(32'(bus.edit_x), 32'(bus.edit_y), 32'(P_PARAM_N)));

   // FSM next state, board/generation updates and command handling.
   always_comb begin
      state_d      = state_q;
      lat_d        = lat_q;
      board_d      = board_q;
      gen_d        = gen_q;
      ack_d        = 1'b0;
      pend_d       = pend_q;
      clear_exec_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.clear) begin
               board_d      = '0;
               gen_d        = '0;
               clear_exec_s = 1'b1;
            end else if (bus.edit_valid) begin
               ack_d = 1'b1;
               if (edit_hit_s) begin
                  board_d[cell_sel_s] = bus.edit_val;
               end else begin
                  board_d = board_q;
               end
            end else if (trig_s) begin
               state_d = ST_EVOLVE;
               lat_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EVOLVE: begin
            if (bus.clear) begin
               pend_d = 1'b1;
            end else begin
               pend_d = pend_q;
            end
            if (lat_q == LAT_LAST) begin
               state_d = ST_COMMIT;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
            // A clear seen during the evolution wins over the evolved board.
            if (pend_q || bus.clear) begin
               board_d      = '0;
               gen_d        = '0;
               pend_d       = 1'b0;
               clear_exec_s = 1'b1;
            end else begin
               board_d = bus.evo_next;
               gen_d   = gen_q + P_GEN_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Controller state, board and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         lat_q   <= '0;
         board_q <= '0;
         gen_q   <= '0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         board_q <= board_d;
         gen_q   <= gen_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.board_prev = board_q;
   assign bus.board      = board_q;
   assign bus.generation = gen_q;
   assign bus.busy       = busy_q;
   assign bus.edit_ack   = ack_q;
endmodule
